mult_share_scheduler: RTL

//  Shares one clock-gated exact 8x8 multiplier (registered Y, updates on clk edge while en=1)

---
 rtl/mult_sched_pkg.sv | 22 ++
 rtl/mult_share_scheduler_rr_arbiter.sv | 45 ++++
 rtl/mult_share_scheduler.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mult_sched_pkg.sv
// ============================================================================
// Module : mult_sched_pkg
// Brief  : Shared types and widths for the shared-multiplier scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mult_sched_pkg;

   localparam int OPND_W = 8;
   localparam int PROD_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_CAPT = 2'd2,
      ST_RESP = 2'd3
   } state_e;

endpackage

`default_nettype wire

// File: rtl/mult_share_scheduler_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick: lowest request at or above ptr_i,
//          wrapping to the lowest request overall. Pointer lives in the parent.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
   import mult_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [ID_W-1:0]    idx_o,
   output logic               any_o
);

   logic [NUM_REQ-1:0] mask;
   logic [NUM_REQ-1:0] masked;
   logic [NUM_REQ-1:0] pick;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_mask
      assign mask[i] = (ID_W'(i) >= ptr_i);
   end

   assign masked = req_i & mask;
   assign pick   = (|masked) ? masked : req_i;
   assign any_o  = |req_i;

   always_comb begin
      idx_o   = '0;
      grant_o = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (pick[i]) idx_o = ID_W'(i);
      end
      if (any_o) grant_o[idx_o] = 1'b1;
   end

endmodule

`default_nettype wire

// File: rtl/mult_share_scheduler.sv
// ============================================================================
// Module : mult_share_scheduler
// Brief  : Round-robin scheduler sharing one clock-gated 8x8 multiplier.
//          Optional macro MULT_SCHED_STATS_EN adds gated_cycles / op_count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_share_scheduler
   import mult_sched_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int ID_W     = 2,
   parameter int MULT_LAT = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [OPND_W*NUM_REQ-1:0]   req_a,
   input  logic [OPND_W*NUM_REQ-1:0]   req_b,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [PROD_W-1:0]           rsp_y,
   output logic [ID_W-1:0]             rsp_id,
   output logic                        mult_en,
   output logic [OPND_W-1:0]           mult_a,
   output logic [OPND_W-1:0]           mult_b,
   input  logic [PROD_W-1:0]           mult_y,
   output logic                        busy
`ifdef MULT_SCHED_STATS_EN
   ,
   output logic [31:0]                 gated_cycles,
   output logic [31:0]                 op_count
`endif
);

   state_e              state_q;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]     id_q;
   logic [1:0]          cnt_q;
   logic [OPND_W-1:0]   a_d, b_d, mult_a_q, mult_b_q;
   logic                mult_en_q, rsp_valid_q;
   logic [PROD_W-1:0]   rsp_y_q;
   logic [ID_W-1:0]     rsp_id_q;
   logic [NUM_REQ-1:0]  gnt;
   logic [ID_W-1:0]     gnt_idx;
   logic                gnt_any;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req_i   (req_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (gnt),
      .idx_o   (gnt_idx),
      .any_o   (gnt_any)
   );

   always_comb begin
      a_d = '0;
      b_d = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            a_d = req_a[OPND_W*i +: OPND_W];
            b_d = req_b[OPND_W*i +: OPND_W];
         end
      end
   end

   assign rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

   // Accept pulse is combinational so operands are sampled in the grant cycle.
   assign req_ready = (state_q == ST_IDLE && rst_n) ? gnt : '0;
   assign busy      = (state_q != ST_IDLE);
   assign mult_en   = mult_en_q;
   assign mult_a    = mult_a_q;
   assign mult_b    = mult_b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_y     = rsp_y_q;
   assign rsp_id    = rsp_id_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         id_q        <= '0;
         cnt_q       <= '0;
         mult_en_q   <= 1'b0;
         mult_a_q    <= '0;
         mult_b_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_y_q     <= '0;
         rsp_id_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (gnt_any) begin
                  mult_a_q  <= a_d;
                  mult_b_q  <= b_d;
                  id_q      <= gnt_idx;
                  rr_ptr_q  <= rr_ptr_d;
                  cnt_q     <= 2'(MULT_LAT - 1);
                  mult_en_q <= 1'b1;
                  state_q   <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (cnt_q == 2'd0) begin
                  mult_en_q <= 1'b0;
                  state_q   <= ST_CAPT;
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
            ST_CAPT: begin
               rsp_y_q     <= mult_y;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef MULT_SCHED_STATS_EN
   logic [31:0] gated_q, ops_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gated_q <= '0;
         ops_q   <= '0;
      end else begin
         if (!mult_en_q && gated_q != 32'hFFFF_FFFF) gated_q <= gated_q + 32'd1;
         if (rsp_valid_q && rsp_ready && ops_q != 32'hFFFF_FFFF) ops_q <= ops_q + 32'd1;
      end
   end

   assign gated_cycles = gated_q;
   assign op_count     = ops_q;
`endif

endmodule

`default_nettype wire
